// File: rtl/polaris_fetch_queue_pkg.sv
// polaris_fetch_queue_pkg: shared widths, reset vector, fault causes and fetch-entry sizing
package polaris_fetch_queue_pkg;
   localparam int XLEN_DEFAULT = 64;
   localparam int ILEN = 32;
   localparam logic [63:0] RESET_VECTOR = 64'hFFFF_FFFF_FFFF_FF00;
   localparam logic [1:0] ISIZ_WORD = 2'b10;
   typedef enum logic [3:0] {CAUSE_IMISALIGN = 4'd0, CAUSE_IACCESS = 4'd1} cause_e;
   // A fetch entry is packed as {inst, pc, fault, cause}.
   function automatic int entry_width(input int xlen);
      return ILEN + xlen + 1 + 4;
   endfunction
endpackage

// File: rtl/polaris_fetch_queue_if.sv
// polaris_fetch_queue_if: I-bus, redirect and sequencer handshake signals of the fetch queue
//   master: fetch-queue view (drives bus request and queue head)
//   slave : bus/sequencer view (drives ack, data, redirect and ready)
interface polaris_fetch_queue_if #(
   parameter int XLEN  = 64,
   parameter int DEPTH = 4
);
   logic [XLEN-1:0]              iadr_o;
   logic [1:0]                   isiz_o;
   logic                         istb_o;
   logic                         iack_i;
   logic                         ierr_i;
   logic [31:0]                  idat_i;
   logic                         redirect_i;
   logic [XLEN-1:0]              redirect_pc_i;
   logic                         inst_valid_o;
   logic [31:0]                  inst_o;
   logic [XLEN-1:0]              inst_pc_o;
   logic                         inst_fault_o;
   logic [3:0]                   inst_cause_o;
   logic                         inst_ready_i;
   logic [$clog2(DEPTH+1)-1:0]   level_o;
   modport master (
      output iadr_o, isiz_o, istb_o, inst_valid_o, inst_o, inst_pc_o, inst_fault_o, inst_cause_o, level_o,
      input  iack_i, ierr_i, idat_i, redirect_i, redirect_pc_i, inst_ready_i
   );
   modport slave (
      input  iadr_o, isiz_o, istb_o, inst_valid_o, inst_o, inst_pc_o, inst_fault_o, inst_cause_o, level_o,
      output iack_i, ierr_i, idat_i, redirect_i, redirect_pc_i, inst_ready_i
   );
endinterface

// File: rtl/polaris_fetch_queue_sync_fifo.sv
// polaris_sync_fifo: registered FIFO with flush, occupancy and head output
//   clk_i/reset_i: clock, async active-high reset
//   push/din: enqueue; pop: dequeue head (ignored when empty or flushing)
//   flush: empty the FIFO; a simultaneous push lands as the only entry
//   head/valid/level: head entry, non-empty flag, occupancy
module polaris_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           head,
   output logic                       valid,
   output logic [$clog2(DEPTH+1)-1:0] level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd, wr;
   logic             do_push, do_pop;
   always_comb begin
      do_push = push & (flush | (level != LW'(DEPTH)));
      do_pop  = pop & valid & !flush;
   end
   always_ff @(posedge clk_i)
      if (do_push) mem[flush ? '0 : wr] <= din;
   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) begin
         rd    <= '0;
         wr    <= '0;
         level <= '0;
      end else if (flush) begin
         rd    <= '0;
         wr    <= AW'(do_push);
         level <= LW'(do_push);
      end else begin
         rd    <= rd + AW'(do_pop);
         wr    <= wr + AW'(do_push);
         level <= level + LW'(do_push) - LW'(do_pop);
      end
   assign valid = level != '0;
   assign head  = mem[rd];
endmodule

// File: rtl/polaris_fetch_queue.sv
// polaris_fetch_queue: instruction-fetch front end owning the fetch PC, I-bus requests and a prefetch queue
//   clk_i/reset_i: clock, async active-high reset
//   bus (master): I-bus request/ack, redirect, and {inst, pc, fault, cause} head handshake with occupancy
module polaris_fetch_queue #(
   parameter int          XLEN         = polaris_fetch_queue_pkg::XLEN_DEFAULT,
   parameter int          DEPTH        = 4,
   parameter logic [63:0] RESET_VECTOR = polaris_fetch_queue_pkg::RESET_VECTOR
) (
   input  logic             clk_i,
   input  logic             reset_i,
   polaris_fetch_queue_if.master bus
);
   import polaris_fetch_queue_pkg::*;
   localparam int EW = entry_width(XLEN);
   localparam int LW = $clog2(DEPTH+1);
   // fpc is the next address to fetch; adr is the address on the bus, which
   // must stay put while a killed request is still waiting for its ack.
   logic [XLEN-1:0] fpc, adr, fpc_n;
   logic            istb, kill, halt;
   logic            ack, held, mis, push, pop, halt_n, kill_n, istb_n;
   logic [3:0]      cause_n;
   logic [LW-1:0]   level, level_n;
   logic [EW-1:0]   din, head;
   logic            valid;
   always_comb begin
      ack     = istb & bus.iack_i;
      held    = istb & !bus.iack_i;
      mis     = bus.redirect_i & (bus.redirect_pc_i[1:0] != 2'b00);
      pop     = valid & bus.inst_ready_i & !bus.redirect_i;
      push    = bus.redirect_i ? mis : ack & !kill;
      cause_n = bus.ierr_i ? CAUSE_IACCESS : CAUSE_IMISALIGN;
      din     = bus.redirect_i ? {ILEN'(0), bus.redirect_pc_i, 1'b1, CAUSE_IMISALIGN}
                               : {bus.ierr_i ? ILEN'(0) : bus.idat_i, fpc, bus.ierr_i, cause_n};
      fpc_n   = bus.redirect_i ? bus.redirect_pc_i : push ? fpc + XLEN'(4) : fpc;
      halt_n  = bus.redirect_i ? mis : halt | (push & bus.ierr_i);
      // An outstanding request that is not acked on a redirect edge must have its response discarded.
      kill_n  = bus.redirect_i ? held : kill & !ack;
      level_n = bus.redirect_i ? LW'(mis) : level + LW'(push) - LW'(pop);
      // Issuing against next-state occupancy keeps level + outstanding <= DEPTH.
      istb_n  = held | (!halt_n & (level_n < LW'(DEPTH)));
   end
   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) begin
         fpc  <= RESET_VECTOR[XLEN-1:0];
         adr  <= '0;
         istb <= 1'b0;
         kill <= 1'b0;
         halt <= 1'b0;
      end else begin
         fpc  <= fpc_n;
         adr  <= held ? adr : fpc_n;
         istb <= istb_n;
         kill <= kill_n;
         halt <= halt_n;
      end
   polaris_sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .push    (push),
      .pop     (pop),
      .flush   (bus.redirect_i),
      .din     (din),
      .head    (head),
      .valid   (valid),
      .level   (level)
   );
   assign bus.istb_o       = istb;
   assign bus.iadr_o       = istb ? adr : '0;
   assign bus.isiz_o       = istb ? ISIZ_WORD : 2'b00;
   assign bus.inst_valid_o = valid;
   assign bus.inst_o       = valid ? head[EW-1 -: ILEN] : '0;
   assign bus.inst_pc_o    = valid ? head[XLEN+4:5] : '0;
   assign bus.inst_fault_o = valid & head[4];
   assign bus.inst_cause_o = valid ? head[3:0] : 4'd0;
   assign bus.level_o      = level;
endmodule
